// File: rtl/sram_like_arbiter.sv
// N-channel round-robin arbiter onto one sram-like memory port with in-order response routing.
// Optional kseg0/kseg1 physical mapping of m_addr under SRAM_LIKE_ADDR_MAP_EN.
module sram_like_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NCH-1:0]        ch_req,
  input  logic [NCH-1:0]        ch_wr,
  input  logic [2*NCH-1:0]      ch_size,
  input  logic [ADDR_W*NCH-1:0] ch_addr,
  input  logic [DATA_W*NCH-1:0] ch_wdata,
  output logic [NCH-1:0]        ch_addr_ok,
  output logic [NCH-1:0]        ch_data_ok,
  output logic [DATA_W-1:0]     ch_rdata,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [1:0]            m_size,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  err_spurious
);

  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    lock_id_q, lock_id_d;
  logic              lock_q, lock_d;
  logic [IDW-1:0]    fifo_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [IDW-1:0]    grant;
  logic [IDW-1:0]    head_id;
  logic              gnt_vld;
  logic              full, empty, push, pop;
  logic [ADDR_W-1:0] sel_addr;
  int                idx;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head_id = fifo_q[head_q];

  // Locked grant holds the stalled request stable until accepted
  always_comb begin
    grant   = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (lock_q) begin
      grant   = lock_id_q;
      gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!gnt_vld && ch_req[idx]) begin
          gnt_vld = 1'b1;
          grant   = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    m_wr     = 1'b0;
    m_size   = '0;
    sel_addr = '0;
    m_wdata  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == IDW'(i)) begin
        m_wr     = ch_wr[i];
        m_size   = ch_size[2*i +: 2];
        sel_addr = ch_addr[ADDR_W*i +: ADDR_W];
        m_wdata  = ch_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef SRAM_LIKE_ADDR_MAP_EN
  assign m_addr = (sel_addr[31:30] == 2'b10) ?
                  {3'b000, sel_addr[28:0]} : sel_addr;
`else
  assign m_addr = sel_addr;
`endif

  assign m_req    = resetn && gnt_vld && !full;
  assign push     = m_req && m_addr_ok;
  assign pop      = resetn && m_data_ok && !empty;
  assign ch_rdata = m_rdata;
  assign err_spurious = err_q;

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr_ok[i] = push && (grant == IDW'(i));
      ch_data_ok[i] = pop && (head_id == IDW'(i));
    end
  end

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    err_d     = err_q | (m_data_ok && empty);
    if (m_req && !m_addr_ok) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    if (push) begin
      lock_d = 1'b0;
      rr_d   = (grant == IDW'(NCH-1)) ? '0 : grant + IDW'(1);
      tail_d = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= grant;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (NCH=2, DEPTH=4).
// Covers reset, round-robin, stall lock, full queue, routing, spurious.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic [31:0] ch_rdata, m_addr, m_wdata, m_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, err_spurious;
  logic [1:0]  m_size;

  int checks = 0;
  int failures = 0;

`ifdef SRAM_LIKE_ADDR_MAP_EN
  localparam logic [31:0] EXP_MAP = 32'h1FAF_F000;
`else
  localparam logic [31:0] EXP_MAP = 32'hBFAF_F000;
`endif

  sram_like_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [1:0] req, input logic aok,
                     input logic dok, input logic [31:0] rd);
    ch_req    = req;
    m_addr_ok = aok;
    m_data_ok = dok;
    m_rdata   = rd;
    #1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    ch_wr    = 2'b10;
    ch_size  = {2'd1, 2'd2};
    ch_addr  = {32'h0000_0200, 32'h0000_0100};
    ch_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
    drv(2'b00, 1'b0, 1'b0, 32'h0);
    nxt(); nxt();

    // outputs held quiet while reset is asserted
    drv(2'b11, 1'b1, 1'b1, 32'h5);
    chk("rst_mreq", 64'(m_req), 64'h0);
    chk("rst_aok", 64'(ch_addr_ok), 64'h0);
    chk("rst_dok", 64'(ch_data_ok), 64'h0);
    nxt();
    resetn = 1'b1;
    drv(2'b00, 1'b0, 1'b0, 32'h0);
    chk("idle_mreq", 64'(m_req), 64'h0);
    chk("idle_aok", 64'(ch_addr_ok), 64'h0);
    chk("idle_dok", 64'(ch_data_ok), 64'h0);
    chk("idle_err", 64'(err_spurious), 64'h0);
    nxt();

    // contention: grants alternate 0,1,0,1 then queue full
    drv(2'b11, 1'b1, 1'b0, 32'h0);
    chk("c1_aok", 64'(ch_addr_ok), 64'h1);
    chk("c1_addr", 64'(m_addr), 64'h100);
    chk("c1_wr", 64'(m_wr), 64'h0);
    chk("c1_size", 64'(m_size), 64'h2);
    chk("c1_wdata", 64'(m_wdata), 64'hAAAA_0000);
    nxt();
    drv(2'b11, 1'b1, 1'b0, 32'h0);
    chk("c2_aok", 64'(ch_addr_ok), 64'h2);
    chk("c2_addr", 64'(m_addr), 64'h200);
    chk("c2_wr", 64'(m_wr), 64'h1);
    chk("c2_size", 64'(m_size), 64'h1);
    nxt();
    drv(2'b11, 1'b1, 1'b0, 32'h0);
    chk("c3_aok", 64'(ch_addr_ok), 64'h1);
    nxt();
    drv(2'b11, 1'b1, 1'b0, 32'h0);
    chk("c4_aok", 64'(ch_addr_ok), 64'h2);
    nxt();
    drv(2'b11, 1'b1, 1'b1, 32'h11);
    chk("full_mreq", 64'(m_req), 64'h0);
    chk("full_aok", 64'(ch_addr_ok), 64'h0);
    chk("full_dok", 64'(ch_data_ok), 64'h1);
    chk("full_rdata", 64'(ch_rdata), 64'h11);
    nxt();
    drv(2'b11, 1'b1, 1'b1, 32'h12);
    chk("c6_mreq", 64'(m_req), 64'h1);
    chk("c6_aok", 64'(ch_addr_ok), 64'h1);
    chk("c6_dok", 64'(ch_data_ok), 64'h2);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h0);
    chk("c7_dok", 64'(ch_data_ok), 64'h1);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h0);
    chk("c8_dok", 64'(ch_data_ok), 64'h2);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h0);
    chk("c9_dok", 64'(ch_data_ok), 64'h1);
    nxt();

    // stall with rr at ch1: lock keeps ch0 despite ch1 arriving
    ch_addr = {32'h0000_0200, 32'hBFAF_F000};
    drv(2'b01, 1'b0, 1'b0, 32'h0);
    chk("s1_mreq", 64'(m_req), 64'h1);
    chk("s1_addr", 64'(m_addr), 64'(EXP_MAP));
    chk("s1_aok", 64'(ch_addr_ok), 64'h0);
    nxt();
    drv(2'b11, 1'b0, 1'b0, 32'h0);
    chk("s2_addr", 64'(m_addr), 64'(EXP_MAP));
    nxt();
    drv(2'b11, 1'b0, 1'b0, 32'h0);
    chk("s3_addr", 64'(m_addr), 64'(EXP_MAP));
    nxt();
    drv(2'b11, 1'b1, 1'b0, 32'h0);
    chk("s4_aok", 64'(ch_addr_ok), 64'h1);
    chk("s4_addr", 64'(m_addr), 64'(EXP_MAP));
    nxt();
    drv(2'b10, 1'b1, 1'b0, 32'h0);
    chk("s5_aok", 64'(ch_addr_ok), 64'h2);
    chk("s5_addr", 64'(m_addr), 64'h200);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h0);
    chk("s6_dok", 64'(ch_data_ok), 64'h1);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h0);
    chk("s7_dok", 64'(ch_data_ok), 64'h2);
    nxt();

    // routing: accept ch1, ch0, ch1 then three responses
    drv(2'b10, 1'b1, 1'b0, 32'h0);
    chk("r1_aok", 64'(ch_addr_ok), 64'h2);
    nxt();
    drv(2'b01, 1'b1, 1'b0, 32'h0);
    chk("r2_aok", 64'(ch_addr_ok), 64'h1);
    nxt();
    drv(2'b10, 1'b1, 1'b0, 32'h0);
    chk("r3_aok", 64'(ch_addr_ok), 64'h2);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h11);
    chk("r4_dok", 64'(ch_data_ok), 64'h2);
    chk("r4_rdata", 64'(ch_rdata), 64'h11);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h22);
    chk("r5_dok", 64'(ch_data_ok), 64'h1);
    chk("r5_rdata", 64'(ch_rdata), 64'h22);
    nxt();
    drv(2'b00, 1'b0, 1'b1, 32'h33);
    chk("r6_dok", 64'(ch_data_ok), 64'h2);
    chk("r6_rdata", 64'(ch_rdata), 64'h33);
    nxt();

    // spurious response, then reset with two outstanding
    drv(2'b00, 1'b0, 1'b1, 32'h0);
    chk("sp_dok", 64'(ch_data_ok), 64'h0);
    nxt();
    drv(2'b01, 1'b1, 1'b0, 32'h0);
    chk("sp_err", 64'(err_spurious), 64'h1);
    chk("sp_aok0", 64'(ch_addr_ok), 64'h1);
    nxt();
    drv(2'b10, 1'b1, 1'b0, 32'h0);
    chk("sp_aok1", 64'(ch_addr_ok), 64'h2);
    chk("sp_sticky", 64'(err_spurious), 64'h1);
    nxt();
    resetn = 1'b0;
    drv(2'b00, 1'b0, 1'b0, 32'h0);
    nxt();
    resetn = 1'b1;
    drv(2'b00, 1'b0, 1'b1, 32'h44);
    chk("rr_err", 64'(err_spurious), 64'h0);
    chk("rr_dok", 64'(ch_data_ok), 64'h0);
    nxt();
    drv(2'b00, 1'b0, 1'b0, 32'h0);
    chk("rr_err2", 64'(err_spurious), 64'h1);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
